// File: rtl/branch_predictor_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_table
// Brief    : 2-bit counter table plus tagged BTB, bimodal or gshare indexed,
//            with branch and mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_table #(
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 4,
  parameter int TAG_BITS   = 8,
  parameter int MODE       = 0,
  parameter int CTR_INIT   = 1
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 lookup_valid,
  input  logic [31:0]          lookup_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_hist,
  input  logic                 update_taken,
  input  logic [31:0]          update_target,
  input  logic                 update_predicted,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  localparam int          c_entries  = 1 << INDEX_BITS;
  localparam logic [1:0]  c_ctr_init = 2'(CTR_INIT);

  logic [1:0]            r_ctr        [c_entries];
  logic                  r_btb_valid  [c_entries];
  logic [TAG_BITS-1:0]   r_btb_tag    [c_entries];
  logic [31:0]           r_btb_target [c_entries];
  logic [HIST_BITS-1:0]  r_ghr;

  logic [INDEX_BITS-1:0] w_lookup_idx;
  logic [INDEX_BITS-1:0] w_update_idx;
  logic [TAG_BITS-1:0]   w_lookup_tag;
  logic [TAG_BITS-1:0]   w_update_tag;
  logic [HIST_BITS-1:0]  w_ghr_next;
  logic [1:0]            w_ctr_cur;
  logic [1:0]            w_ctr_next;
  logic                  w_hit;
  logic                  w_taken;
  logic [31:0]           w_target;
  logic                  w_unused_bits;

  // Update side indexes with the history the lookup used, not the live GHR.
  generate
    if (MODE == 1) begin : g_gshare
      assign w_lookup_idx = lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(r_ghr);
      assign w_update_idx = update_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(update_hist);
    end else begin : g_bimodal
      assign w_lookup_idx = lookup_pc[INDEX_BITS+1:2];
      assign w_update_idx = update_pc[INDEX_BITS+1:2];
    end
  endgenerate

  generate
    if (HIST_BITS == 1) begin : g_ghr_single
      assign w_ghr_next = update_taken;
    end else begin : g_ghr_shift
      assign w_ghr_next = {r_ghr[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  assign w_lookup_tag  = lookup_pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];
  assign w_update_tag  = update_pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];
  assign w_unused_bits = ^{update_pc, update_hist};

  assign w_hit    = r_btb_valid[w_lookup_idx] && (r_btb_tag[w_lookup_idx] == w_lookup_tag);
  assign w_taken  = r_ctr[w_lookup_idx][1] && w_hit;
  assign w_target = w_taken ? r_btb_target[w_lookup_idx] : lookup_pc + 32'd4;

  assign w_ctr_cur  = r_ctr[w_update_idx];
  assign w_ctr_next = update_taken ? ((w_ctr_cur == 2'd3) ? 2'd3 : w_ctr_cur + 2'd1)
                                   : ((w_ctr_cur == 2'd0) ? 2'd0 : w_ctr_cur - 2'd1);

  // Lookup reads combinationally from the current state, so a same-cycle
  // update is naturally invisible to it (read-before-write).
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < c_entries; i++) begin
        r_ctr[i]        <= c_ctr_init;
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= '0;
      end
      r_ghr            <= '0;
      pred_valid       <= 1'b0;
      pred_taken       <= 1'b0;
      pred_target      <= '0;
      pred_hist        <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) begin
        pred_taken  <= w_taken;
        pred_target <= w_target;
        pred_hist   <= r_ghr;
      end
      if (update_valid) begin
        r_ctr[w_update_idx] <= w_ctr_next;
        if (update_taken) begin
          r_btb_valid[w_update_idx]  <= 1'b1;
          r_btb_tag[w_update_idx]    <= w_update_tag;
          r_btb_target[w_update_idx] <= update_target;
        end
        r_ghr         <= w_ghr_next;
        stat_branches <= stat_branches + 32'd1;
        if (update_predicted != update_taken)
          stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_table
// Brief    : Directed bench; a bimodal and a gshare instance share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_table;

  logic        clk;
  logic        Reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [3:0]  update_hist;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_predicted;

  logic        p0_valid, p0_taken, p1_valid, p1_taken;
  logic [31:0] p0_target, p1_target;
  logic [3:0]  p0_hist, p1_hist;
  logic [31:0] s0_br, s0_mis, s1_br, s1_mis;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor_table #(.INDEX_BITS(6), .HIST_BITS(4), .TAG_BITS(8), .MODE(0), .CTR_INIT(1)) u_dut0 (
    .clk(clk), .Reset(Reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(p0_valid), .pred_taken(p0_taken), .pred_target(p0_target), .pred_hist(p0_hist),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_target(update_target), .update_predicted(update_predicted),
    .stat_branches(s0_br), .stat_mispredicts(s0_mis)
  );

  branch_predictor_table #(.INDEX_BITS(6), .HIST_BITS(4), .TAG_BITS(8), .MODE(1), .CTR_INIT(1)) u_dut1 (
    .clk(clk), .Reset(Reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(p1_valid), .pred_taken(p1_taken), .pred_target(p1_target), .pred_hist(p1_hist),
    .update_valid(update_valid), .update_pc(update_pc), .update_hist(update_hist),
    .update_taken(update_taken), .update_target(update_target), .update_predicted(update_predicted),
    .stat_branches(s1_br), .stat_mispredicts(s1_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic predicted);
    update_valid     = 1'b1;
    update_pc        = pc;
    update_hist      = 4'h0;
    update_taken     = taken;
    update_target    = tgt;
    update_predicted = predicted;
    tick();
    update_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_hist = '0;
    update_taken = 1'b0; update_target = '0; update_predicted = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;

    check("rst_valid",  {31'b0, p0_valid}, 32'h0);
    check("rst_target", p0_target, 32'h0);
    check("rst_stats",  s0_br | s0_mis, 32'h0);

    // Empty BTB predicts fall-through
    do_lookup(32'h100);
    check("first_valid",  {31'b0, p0_valid}, 32'h1);
    check("first_taken",  {31'b0, p0_taken}, 32'h0);
    check("first_target", p0_target, 32'h104);
    check("first_hist",   {28'b0, p0_hist}, 32'h0);
    tick();
    check("idle_valid", {31'b0, p0_valid}, 32'h0);
    check("idle_hold",  p0_target, 32'h104);

    // Train ctr 1 -> 3
    repeat (2) do_update(32'h100, 1'b1, 32'h200, 1'b0);
    do_lookup(32'h100);
    check("train_taken",  {31'b0, p0_taken}, 32'h1);
    check("train_target", p0_target, 32'h200);
    check("train_br",     s0_br, 32'd2);
    check("train_mis",    s0_mis, 32'd2);

    // Saturation both ways
    repeat (3) do_update(32'h100, 1'b1, 32'h200, 1'b1);
    repeat (2) do_update(32'h100, 1'b0, 32'h0, 1'b1);
    do_lookup(32'h100);
    check("sat_hi_taken",  {31'b0, p0_taken}, 32'h0);
    check("sat_hi_target", p0_target, 32'h104);
    repeat (3) do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    do_lookup(32'h100);
    check("sat_lo_taken", {31'b0, p0_taken}, 32'h0);
    check("sat_br",       s0_br, 32'd11);
    check("sat_mis",      s0_mis, 32'd5);

    // Aliasing: same counter, different tag
    repeat (2) do_update(32'h100, 1'b1, 32'h200, 1'b0);
    do_lookup(32'h100);
    check("alias_own_taken", {31'b0, p0_taken}, 32'h1);
    do_lookup(32'h200);
    check("alias_taken",  {31'b0, p0_taken}, 32'h0);
    check("alias_target", p0_target, 32'h204);

    // Same-cycle lookup and update: lookup sees old counter
    repeat (2) do_update(32'h100, 1'b0, 32'h0, 1'b1);
    update_valid = 1'b1; update_pc = 32'h100; update_hist = 4'h0;
    update_taken = 1'b1; update_target = 32'h200; update_predicted = 1'b0;
    do_lookup(32'h100);
    update_valid = 1'b0;
    check("coll_taken",  {31'b0, p0_taken}, 32'h0);
    check("coll_target", p0_target, 32'h104);
    do_lookup(32'h100);
    check("coll_next_taken", {31'b0, p0_taken}, 32'h1);

    // Gshare: T,T,N,T trains gshare idx 0 and leaves GHR = 1101
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    do_update(32'h100, 1'b1, 32'h300, 1'b0);
    do_update(32'h100, 1'b1, 32'h300, 1'b0);
    do_update(32'h100, 1'b0, 32'h0,   1'b0);
    do_update(32'h100, 1'b1, 32'h300, 1'b0);
    check("gs_br",  s1_br, 32'd4);
    check("gs_mis", s1_mis, 32'd3);
    do_lookup(32'h100);
    check("gs_hist",      {28'b0, p1_hist}, 32'hD);
    check("gs_miss",      {31'b0, p1_taken}, 32'h0);
    check("gs_miss_tgt",  p1_target, 32'h104);
    check("bm_hit",       {31'b0, p0_taken}, 32'h1);
    check("bm_hit_tgt",   p0_target, 32'h300);
    do_lookup(32'h134);
    check("gs_hit",     {31'b0, p1_taken}, 32'h1);
    check("gs_hit_tgt", p1_target, 32'h300);
    check("bm_miss_tgt", p0_target, 32'h138);

    // Asynchronous reset between edges, with traffic in flight
    lookup_valid = 1'b1; lookup_pc = 32'h134;
    update_valid = 1'b1; update_pc = 32'h134; update_taken = 1'b1;
    update_target = 32'h400; update_predicted = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check("arst_valid",  {31'b0, p1_valid}, 32'h0);
    check("arst_target", p1_target, 32'h0);
    check("arst_br",     s1_br, 32'h0);
    tick();
    Reset = 1'b0;
    update_valid = 1'b0;
    do_lookup(32'h134);
    check("post_valid",  {31'b0, p1_valid}, 32'h1);
    check("post_taken",  {31'b0, p1_taken}, 32'h0);
    check("post_target", p1_target, 32'h138);
    check("post_hist",   {28'b0, p1_hist}, 32'h0);
    check("post_br",     s1_br, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
Parametrised dynamic branch predictor for the fetch stage. It replaces the single shared 2-bit predictor with a table of 2-bit saturating counters and a tagged branch target buffer (BTB). Indexing is selectable between bimodal (PC) and gshare (PC XOR global history). Lookups come from fetch. Updates come from the execute stage once the branch resolves. Hit/mispredict statistics are included.

Parameters:
INDEX_BITS, 6, log2 of table entries (64); legal range 2..10
HIST_BITS, 4, global history length; must satisfy 1 <= HIST_BITS <= INDEX_BITS
TAG_BITS, 8, BTB tag width taken from PC above the index field
MODE, 0, 0 = bimodal index, 1 = gshare index
CTR_INIT, 1, reset value of every counter (0..3)

Ports:
clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
lookup_valid  in  1  fetch requests a prediction this cycle
lookup_pc  in  32  PC of the fetched instruction
pred_valid  out  1  registered; prediction outputs valid this cycle
pred_taken  out  1  predicted direction
pred_target  out  32  predicted next PC
pred_hist  out  HIST_BITS  GHR snapshot used for this lookup; pipeline carries it to update
update_valid  in  1  a resolved branch is reported
update_pc  in  32  PC of the resolved branch
update_hist  in  HIST_BITS  pred_hist returned from this branch's lookup
update_taken  in  1  actual outcome
update_target  in  32  actual taken target
update_predicted  in  1  pred_taken that was issued for this branch
stat_branches  out  32  count of update_valid cycles, wraps
stat_mispredicts  out  32  count of updates with update_predicted != update_taken, wraps

Behaviour:
- Index, bimodal: idx = pc[INDEX_BITS+1:2].
- Index, gshare: idx = pc[INDEX_BITS+1:2] XOR zero-extended history. Lookup uses the current GHR; update uses update_hist.
- Tag: pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2].
- Per entry: ctr[1:0], btb_valid, btb_tag, btb_target[31:0].
- Lookup latency is 1 cycle: inputs sampled at edge N, outputs valid after edge N.
  - pred_valid = registered lookup_valid.
  - When lookup_valid=0, pred_valid=0 and the other pred_* outputs hold their previous values.
- Lookup result:
  - hit = btb_valid && btb_tag == tag(lookup_pc).
  - pred_taken = ctr[1] && hit.
  - pred_target = btb_target if pred_taken, else lookup_pc + 4 (32-bit wrap).
  - pred_hist = GHR value used for the index.
- Update, applied at the edge where update_valid=1:
  - Counter at idx(update_pc, update_hist) saturates: taken -> min(ctr+1, 3); not taken -> max(ctr-1, 0).
  - If update_taken=1: btb_valid <= 1, btb_tag <= tag(update_pc), btb_target <= update_target. This overwrites on tag conflict.
  - If update_taken=0, the BTB is unchanged.
  - GHR <= {GHR[HIST_BITS-2:0], update_taken}. For HIST_BITS=1, GHR <= update_taken. GHR is non-speculative.
  - stat_branches += 1; stat_mispredicts += 1 when update_predicted != update_taken. Both wrap at 2^32.
- Simultaneous lookup and update in the same cycle:
  - The lookup sees pre-update table contents and pre-update GHR (read-before-write), even at the same index.
- Reset (async, any time including mid-stream):
  - All ctr = CTR_INIT; all btb_valid = 0; GHR = 0.
  - pred_valid = 0, pred_taken = 0, pred_target = 0, pred_hist = 0.
  - Both stat counters = 0.
  - A lookup or update in flight is discarded. The first lookup after reset deassertion predicts not-taken (BTB empty).
- Table storage holds the same contents in either MODE; only the index function differs.
- Counter and BTB storage are flops; no reset-free RAM is permitted.

Test Plan:
- Reset -> lookup pc=0x100: next cycle pred_valid=1, pred_taken=0, pred_target=0x104, pred_hist=0; both stats = 0.
- MODE=0: two taken updates pc=0x100, target=0x200, update_predicted=0 (ctr 1->2->3) -> lookup 0x100 gives pred_taken=1, pred_target=0x200; stat_branches=2, stat_mispredicts=2.
- Saturation: from ctr=3, apply 3 more taken, then 2 not-taken -> ctr=1, lookup 0x100 gives not-taken, target 0x104. Then 3 not-taken -> ctr=0; one taken -> ctr=1, still not-taken.
- Aliasing/tag: train 0x100 taken to ctr=3, then lookup 0x100 + (1 << (INDEX_BITS+2)) = 0x200 -> same counter but tag miss -> pred_taken=0, target 0x204.
- Same-cycle collision: with ctr=1, lookup 0x100 together with taken update 0x100 -> pred_taken=0; a repeat lookup next cycle gives pred_taken=1 (ctr=2).
- MODE=1, HIST_BITS=4: updates T,T,N,T give GHR=4'b1101; lookup 0x100 uses idx=0x00^0xD=0xD and pred_hist=4'hD. Assert Reset mid-sequence -> GHR=0, pred_valid=0 immediately, BTB cleared.
